muldiv_sequencer: RTL and testbench

- Multi-cycle sequencer for the RV32M extension in the EX stage.
- Accepts an M-type op (opcode R-type, funct7 0000001) from decode/EX and holds the pipeline with `stall_out` while it runs.
- Multiplies complete in MUL_CYCLES cycles; divides and remainders use a 32-iteration restoring divider.
- Presents a one-cycle `result_valid` pulse with the 32-bit writeback value.

---
 rtl/muldiv_sequencer.sv | 137 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer for the EX stage: fixed-latency multiply,
// 32-step restoring divide, one-cycle result_valid pulse with a held result.
module muldiv_sequencer #(
  parameter int MUL_CYCLES = 2,
  parameter int XLEN       = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  func3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        stall_out,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [2:0]  f3;
  logic [31:0] op_a;   // multiplicand, or dividend shifting into quotient
  logic [31:0] op_b;   // multiplier, or divisor magnitude
  logic [31:0] rem;
  logic        q_neg, r_neg;

  // ---- accept-cycle decode
  logic        accept, in_signed, div_zero, div_ovf;
  logic [31:0] abs_a, abs_b, special_res;

  assign accept    = (state == S_IDLE) && start && !flush;
  assign in_signed = !func3[0];
  assign div_zero  = (rs2 == 32'd0);
  assign div_ovf   = in_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
  assign abs_a     = (in_signed && rs1[31]) ? -rs1 : rs1;
  assign abs_b     = (in_signed && rs2[31]) ? -rs2 : rs2;

  always_comb begin
    special_res = 32'd0;
    if (div_zero)     special_res = func3[1] ? rs1 : 32'hFFFF_FFFF;
    else if (div_ovf) special_res = func3[1] ? 32'd0 : 32'h8000_0000;
  end

  // ---- multiply: 33x33 signed product of sign/zero-extended operands
  logic               a_sx, b_sx;
  logic signed [65:0] a_w, b_w, product;
  logic [31:0]        mul_res;

  assign a_sx    = (f3 != 3'd3) && op_a[31];
  assign b_sx    = (f3 == 3'd0 || f3 == 3'd1) && op_b[31];
  assign a_w     = {{34{a_sx}}, op_a};
  assign b_w     = {{34{b_sx}}, op_b};
  assign product = a_w * b_w;
  assign mul_res = (f3 == 3'd0) ? product[31:0] : product[63:32];

  // ---- one restoring divide step; sign fix-up folded in for the last step
  logic [32:0] trial, diff;
  logic        ge;
  logic [31:0] rem_n, quo_n, div_res;

  assign trial   = {rem, op_a[31]};
  assign diff    = trial - {1'b0, op_b};
  assign ge      = (trial >= {1'b0, op_b});
  assign rem_n   = ge ? diff[31:0] : trial[31:0];
  assign quo_n   = {op_a[30:0], ge};
  assign div_res = f3[1] ? (r_neg ? -rem_n : rem_n) : (q_neg ? -quo_n : quo_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= 5'd0;
      f3     <= 3'd0;
      op_a   <= 32'd0;
      op_b   <= 32'd0;
      rem    <= 32'd0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      result <= 32'd0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          f3 <= func3;
          if (!func3[2]) begin
            op_a  <= rs1;
            op_b  <= rs2;
            cnt   <= MUL_LAST;
            state <= S_MUL;
          end else if (div_zero || div_ovf) begin
            result <= special_res;
            state  <= S_DONE;
          end else begin
            op_a  <= abs_a;
            op_b  <= abs_b;
            rem   <= 32'd0;
            q_neg <= in_signed && (rs1[31] ^ rs2[31]);
            r_neg <= in_signed && rs1[31];
            cnt   <= 5'd31;
            state <= S_DIV;
          end
        end
        S_MUL: begin
          if (flush) state <= S_IDLE;
          else if (cnt == 5'd0) begin
            result <= mul_res;
            state  <= S_DONE;
          end else cnt <= cnt - 5'd1;
        end
        S_DIV: begin
          if (flush) state <= S_IDLE;
          else begin
            op_a <= quo_n;
            rem  <= rem_n;
            cnt  <= cnt - 5'd1;
            if (cnt == 5'd0) begin
              result <= div_res;
              state  <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy         = (state == S_MUL) || (state == S_DIV);
  assign result_valid = (state == S_DONE);
  assign stall_out    = rst_n && (accept || busy);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, results, special cases,
// flush, async reset and back-to-back issue.
module tb_muldiv_sequencer;
  localparam int MC = 2;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  func3;
  logic [31:0] rs1, rs2;
  logic        stall_out, busy, result_valid;
  logic [31:0] result;

  int cmp_cnt = 0;
  int err_cnt = 0;

  muldiv_sequencer #(.MUL_CYCLES(MC), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func3(func3), .rs1(rs1), .rs2(rs2),
    .flush(flush), .stall_out(stall_out), .busy(busy),
    .result_valid(result_valid), .result(result)
  );

  always #5 clk = ~clk;

  // Issue one op at a negedge; returns cycles from accept T to result_valid.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int  lat;
    logic stall_ok;
    @(negedge clk);
    func3 = f; rs1 = a; rs2 = b; start = 1'b1;
    #1;
    cmp_cnt++;
    if (stall_out !== 1'b1) begin
      err_cnt++; $display("FAIL %s accept_stall: got %b want 1", name, stall_out);
    end
    @(negedge clk);
    start = 1'b0; rs1 = $urandom; rs2 = $urandom;
    lat = 1; stall_ok = 1'b1;
    while (result_valid !== 1'b1 && lat < 60) begin
      if (stall_out !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    cmp_cnt++;
    if (lat !== exp_lat) begin
      err_cnt++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    cmp_cnt++;
    if (result !== exp) begin
      err_cnt++; $display("FAIL %s result: got %h want %h", name, result, exp);
    end
    cmp_cnt++;
    if (!stall_ok || stall_out !== 1'b0) begin
      err_cnt++; $display("FAIL %s stall_window: stall_ok=%b done_stall=%b want 1/0", name, stall_ok, stall_out);
    end
    @(negedge clk);
    cmp_cnt++;
    if (result_valid !== 1'b0) begin
      err_cnt++; $display("FAIL %s pulse_width: valid=%b want 0", name, result_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; flush = 1'b0; func3 = 3'd0; rs1 = 32'd5; rs2 = 32'd6;
    #12;
    cmp_cnt++;
    if ({stall_out, busy, result_valid, result} !== 35'd0) begin
      err_cnt++; $display("FAIL reset_outputs: got %b%b%b %h want 0", stall_out, busy, result_valid, result);
    end
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mul();
    run_op("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MC + 1);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, MC + 1);
    run_op("mulhsu", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, MC + 1);
    run_op("mulhu",  3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, MC + 1);
  endtask

  task automatic test_div();
    run_op("div",  3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);
    run_op("rem",  3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);
    run_op("divu", 3'd5, 32'd100,       32'd7, 32'd14,        33);
    run_op("remu", 3'd7, 32'd100,       32'd7, 32'd2,         33);
  endtask

  task automatic test_special();
    run_op("divu_zero", 3'd5, 32'h1234,      32'd0,         32'hFFFF_FFFF, 1);
    run_op("remu_zero", 3'd7, 32'h1234,      32'd0,         32'h0000_1234, 1);
    run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
  endtask

  task automatic test_flush();
    logic [31:0] prior;
    logic        seen;
    run_op("pre_flush", 3'd5, 32'd50, 32'd5, 32'd10, 33);
    prior = result;
    @(negedge clk);
    func3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;                 // cycle T+1
    repeat (9) @(negedge clk);                    // cycle T+10
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;                 // cycle T+11
    cmp_cnt++;
    if (stall_out !== 1'b0 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL flush_idle: stall=%b busy=%b want 0/0", stall_out, busy);
    end
    seen = 1'b0;
    repeat (40) begin
      if (result_valid === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    cmp_cnt++;
    if (seen !== 1'b0 || result !== prior) begin
      err_cnt++; $display("FAIL flush_no_result: valid_seen=%b result=%h want 0/%h", seen, result, prior);
    end
    // start with flush in IDLE is not accepted
    start = 1'b1; flush = 1'b1; func3 = 3'd0;
    @(negedge clk);
    cmp_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++; $display("FAIL flush_ignore_start: busy=%b want 0", busy);
    end
    start = 1'b0; flush = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    func3 = 3'd4; rs1 = 32'd77; rs2 = 32'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;                 // T+1
    repeat (3) @(negedge clk);                    // T+4
    #2 start = 1'b1; rst_n = 1'b0;                // mid-cycle, away from edges
    #1;
    cmp_cnt++;
    if ({stall_out, busy, result_valid, result} !== 35'd0) begin
      err_cnt++; $display("FAIL async_reset: got %b%b%b %h want 0", stall_out, busy, result_valid, result);
    end
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_op("mulhu_after_rst", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MC + 1);
  endtask

  task automatic test_back_to_back();
    int cyc, first, second;
    first = -1; second = -1;
    @(negedge clk);
    func3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4; start = 1'b1;
    for (cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
      end
    end
    start = 1'b0;
    cmp_cnt++;
    if (first < 0 || second < 0 || (second - first) !== MC + 2) begin
      err_cnt++; $display("FAIL back_to_back_gap: first=%0d second=%0d want gap %0d", first, second, MC + 2);
    end
    cmp_cnt++;
    if (result !== 32'd12) begin
      err_cnt++; $display("FAIL back_to_back_result: got %h want 0000000c", result);
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
